// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES SubBytes datapath:
//   - AES_ENC / AES_DEC mode encodings for the enc_dec control bit
//   - AES_STATE_BYTES   default state size in bytes
//   - aes_state_e       engine FSM state encoding
//   - AES_SBOX          forward S-box table (FIPS-197), indexed by input byte
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic AES_ENC = 1'b1;
  localparam logic AES_DEC = 1'b0;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_subbytes_engine_if.sv
// ---------------------------------------------------------------------------
// aes_subbytes_engine_if
// Handshake bundle between the SubBytes engine and its neighbours.
//   in_valid/in_ready   : input state handshake, data_in + enc_dec qualified
//   data_in             : input state, byte n at [8n+7:8n]
//   enc_dec             : 1 = forward S-box, 0 = inverse S-box
//   out_valid/out_ready : output state handshake
//   data_out            : substituted state, same byte order as data_in
//   busy                : engine is substituting (BUSY state)
// Modports: master = upstream/downstream side, slave = engine side.
// ---------------------------------------------------------------------------
interface aes_subbytes_engine_if
  import aes_pkg::*;
#(
  parameter int STATE_BYTES = AES_STATE_BYTES
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [8*STATE_BYTES-1:0] data_in;
  logic                     enc_dec;
  logic                     out_valid;
  logic                     out_ready;
  logic [8*STATE_BYTES-1:0] data_out;
  logic                     busy;

  modport master (
    output in_valid, data_in, enc_dec, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, enc_dec, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox / aes_inv_sbox
// Byte-wide forward and inverse AES S-boxes, purely combinational.
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = AES_SBOX[i_byte];

endmodule

module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Inverse table is derived from the forward table so the two can never
  // disagree; synthesis folds the search into an 8-input constant table.
  always_comb begin
    o_byte = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (AES_SBOX[i] == i_byte) o_byte = 8'(i);
    end
  end

endmodule

// File: rtl/aes_subbytes_engine_lane.sv
// ---------------------------------------------------------------------------
// aes_subbytes_lane
// One shared SubBytes lane: forward and inverse S-box, mode-selected.
//   i_byte : byte to substitute
//   i_mode : AES_ENC selects forward S-box, AES_DEC selects inverse
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_subbytes_lane
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_mode,
  output logic [7:0] o_byte
);

  logic [7:0] w_fwd;
  logic [7:0] w_inv;

  // Both tables are always driven by the same byte so switching activity
  // does not depend on the mode.
  aes_sbox u_fwd (
    .i_byte (i_byte),
    .o_byte (w_fwd)
  );

  aes_inv_sbox u_inv (
    .i_byte (i_byte),
    .o_byte (w_inv)
  );

  assign o_byte = (i_mode == AES_ENC) ? w_fwd : w_inv;

endmodule

// File: rtl/aes_subbytes_engine.sv
// ---------------------------------------------------------------------------
// aes_subbytes_engine
// Multi-cycle in-place SubBytes over a full AES state using LANES shared
// S-box lanes; STATE_BYTES/LANES beats per state.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : aes_subbytes_engine_if.slave (in/out handshakes, data, busy)
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready=1
//   BUSY  | substituting LANES bytes per cycle
//   DONE  | result held on data_out, out_valid=1
// ---------------------------------------------------------------------------
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int STATE_BYTES = AES_STATE_BYTES,
  parameter int LANES       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_subbytes_engine_if.slave  bus
);

  localparam int ITERS = STATE_BYTES / LANES;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  if (LANES < 1 || (STATE_BYTES % LANES) != 0) begin : g_bad_cfg
    $error("aes_subbytes_engine: STATE_BYTES must be a non-zero multiple of LANES");
  end

  aes_state_e               r_state;
  aes_state_e               w_next_state;
  logic [8*STATE_BYTES-1:0] r_work;
  logic [8*STATE_BYTES-1:0] w_work_next;
  logic                     r_mode;
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_last_beat;
  logic                     w_accept;
  logic                     w_in_ready;
  logic                     w_out_valid;
  logic                     w_busy;
  logic [7:0]               w_lane_in  [LANES];
  logic [7:0]               w_lane_out [LANES];

  assign w_last_beat = (r_cnt == CNT_W'(ITERS - 1));
  assign w_accept    = bus.in_valid & w_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_next_state = ST_BUSY;
      ST_BUSY: if (w_last_beat)  w_next_state = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) w_next_state = bus.in_valid ? ST_BUSY : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode; in_ready is held low while reset is applied so nothing
  // upstream believes a state was taken during that cycle.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_BUSY: w_busy     = 1'b1;
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
    if (rst) w_in_ready = 1'b0;
  end

  // Lane i works on byte k*LANES+i during beat k.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_in[i] = 8'h00;
      for (int k = 0; k < ITERS; k++) begin
        if (r_cnt == CNT_W'(k)) w_lane_in[i] = r_work[8*(k*LANES + i) +: 8];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_subbytes_lane u_lane (
      .i_byte (w_lane_in[g]),
      .i_mode (r_mode),
      .o_byte (w_lane_out[g])
    );
  end

  always_comb begin
    w_work_next = r_work;
    for (int j = 0; j < STATE_BYTES; j++) begin
      if (r_cnt == CNT_W'(j / LANES)) w_work_next[8*j +: 8] = w_lane_out[j % LANES];
    end
  end

  // Working register, latched mode and beat counter. The counter wraps to
  // zero on the last beat so it never indexes past the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_mode <= AES_DEC;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_work <= bus.data_in;
      r_mode <= bus.enc_dec;
      r_cnt  <= '0;
    end else if (r_state == ST_BUSY) begin
      r_work <= w_work_next;
      r_cnt  <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.data_out  = r_work;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
module tb_aes_subbytes_engine;
  import aes_pkg::*;

  localparam int SB   = 16;
  localparam int NDUT = 3;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         tb_in_valid  [NDUT];
  logic         tb_enc_dec   [NDUT];
  logic         tb_out_ready [NDUT];
  logic [127:0] tb_data_in   [NDUT];
  wire          w_in_ready   [NDUT];
  wire          w_out_valid  [NDUT];
  wire          w_busy       [NDUT];
  wire  [127:0] w_data_out   [NDUT];

  // DUT 0: LANES=4, DUT 1: LANES=1, DUT 2: LANES=16
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    aes_subbytes_engine_if #(.STATE_BYTES(SB)) u_if ();
    assign u_if.in_valid  = tb_in_valid[g];
    assign u_if.enc_dec   = tb_enc_dec[g];
    assign u_if.out_ready = tb_out_ready[g];
    assign u_if.data_in   = tb_data_in[g];
    assign w_in_ready[g]  = u_if.in_ready;
    assign w_out_valid[g] = u_if.out_valid;
    assign w_busy[g]      = u_if.busy;
    assign w_data_out[g]  = u_if.data_out;
    aes_subbytes_engine #(.STATE_BYTES(SB), .LANES(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );
  end

  typedef struct {
    logic [127:0] din;
    logic         mode;
    logic [127:0] dout;
    string        name;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!w_out_valid[d] && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_txn(input int d, input logic [127:0] din, input logic mode,
                         input logic [127:0] dout, input string name);
    int lat;
    tb_data_in[d]   = din;
    tb_enc_dec[d]   = mode;
    tb_in_valid[d]  = 1'b1;
    tb_out_ready[d] = 1'b0;
    #1;
    check({name, " in_ready"}, 128'(w_in_ready[d]), 128'(1));
    tick();
    tb_in_valid[d] = 1'b0;
    tb_data_in[d]  = rnd128();
    tb_enc_dec[d]  = ~mode;
    wait_out(d, lat);
    check({name, " latency"}, 128'(lat), 128'(lat_of(d)));
    check({name, " data"}, w_data_out[d], dout);
    tb_out_ready[d] = 1'b1;
    tick();
    tb_out_ready[d] = 1'b0;
    check({name, " out_valid drop"}, 128'(w_out_valid[d]), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;

    for (int d = 0; d < NDUT; d++) begin
      tb_in_valid[d]  = 1'b0;
      tb_enc_dec[d]   = 1'b0;
      tb_out_ready[d] = 1'b0;
      tb_data_in[d]   = '0;
    end

    vecs[0] = '{128'h53, AES_ENC, 128'h636363636363636363636363636363ed, "enc single 0x53"};
    vecs[1] = '{FIPS_IN, AES_ENC, FIPS_OUT, "enc fips"};
    vecs[2] = '{FIPS_OUT, AES_DEC, FIPS_IN, "dec fips"};
    vecs[3] = '{128'h0, AES_ENC, {16{8'h63}}, "enc zero"};
    vecs[4] = '{128'h0, AES_DEC, {16{8'h52}}, "dec zero"};
    vecs[5] = '{{16{8'h16}}, AES_DEC, {16{8'hff}}, "dec 0x16"};

    // Reset state, observed while rst is still asserted
    tick();
    tick();
    check("reset in_ready", 128'(w_in_ready[0]), 128'(0));
    check("reset out_valid", 128'(w_out_valid[0]), 128'(0));
    check("reset busy", 128'(w_busy[0]), 128'(0));
    check("reset data_out", w_data_out[0], 128'h0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 128'(w_in_ready[0]), 128'(1));

    // Table-driven vectors on the default configuration
    for (int v = 0; v < 6; v++) run_txn(0, vecs[v].din, vecs[v].mode, vecs[v].dout, vecs[v].name);

    // LANES=1 and LANES=16 round trips
    for (int d = 1; d < NDUT; d++) begin
      run_txn(d, vecs[1].din, vecs[1].mode, vecs[1].dout, $sformatf("L%0d enc fips", (d == 1) ? 1 : 16));
      run_txn(d, vecs[2].din, vecs[2].mode, vecs[2].dout, $sformatf("L%0d dec fips", (d == 1) ? 1 : 16));
    end

    // Mode latch (enc_dec toggled every BUSY cycle) and backpressure
    tb_data_in[0]  = FIPS_IN;
    tb_enc_dec[0]  = AES_ENC;
    tb_in_valid[0] = 1'b1;
    tick();
    tb_in_valid[0] = 1'b0;
    lat = 0;
    while (!w_out_valid[0] && lat < 64) begin
      tb_enc_dec[0] = ~tb_enc_dec[0];
      tick();
      lat++;
    end
    check("latch latency", 128'(lat), 128'(4));
    check("latch data", w_data_out[0], FIPS_OUT);
    for (int c = 0; c < 10; c++) begin
      tb_in_valid[0] = 1'b1;
      tb_data_in[0]  = rnd128();
      #1;
      check($sformatf("hold data c%0d", c), w_data_out[0], FIPS_OUT);
      check($sformatf("hold in_ready c%0d", c), 128'(w_in_ready[0]), 128'(0));
      tick();
    end
    tb_in_valid[0]  = 1'b0;
    tb_out_ready[0] = 1'b1;
    tick();
    tb_out_ready[0] = 1'b0;
    check("hold release out_valid", 128'(w_out_valid[0]), 128'(0));
    check("hold release in_ready", 128'(w_in_ready[0]), 128'(1));

    // Back-to-back accept out of DONE
    tb_data_in[0]  = 128'h0;
    tb_enc_dec[0]  = AES_ENC;
    tb_in_valid[0] = 1'b1;
    tick();
    tb_in_valid[0] = 1'b0;
    wait_out(0, lat);
    check("b2b first data", w_data_out[0], {16{8'h63}});
    tb_out_ready[0] = 1'b1;
    tb_in_valid[0]  = 1'b1;
    tb_data_in[0]   = FIPS_IN;
    tb_enc_dec[0]   = AES_ENC;
    #1;
    check("b2b in_ready", 128'(w_in_ready[0]), 128'(1));
    tick();
    tb_in_valid[0]  = 1'b0;
    tb_out_ready[0] = 1'b0;
    check("b2b busy", 128'(w_busy[0]), 128'(1));
    check("b2b out_valid low", 128'(w_out_valid[0]), 128'(0));
    wait_out(0, lat);
    check("b2b latency", 128'(lat), 128'(4));
    check("b2b second data", w_data_out[0], FIPS_OUT);
    tb_out_ready[0] = 1'b1;
    tick();
    tb_out_ready[0] = 1'b0;

    // Reset during beat 2
    tb_data_in[0]  = FIPS_IN;
    tb_enc_dec[0]  = AES_ENC;
    tb_in_valid[0] = 1'b1;
    tick();
    tb_in_valid[0] = 1'b0;
    tick();
    tick();
    check("abort busy before reset", 128'(w_busy[0]), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort out_valid", 128'(w_out_valid[0]), 128'(0));
    check("abort busy", 128'(w_busy[0]), 128'(0));
    check("abort data_out", w_data_out[0], 128'h0);
    check("abort in_ready", 128'(w_in_ready[0]), 128'(1));
    tb_out_ready[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (w_out_valid[0]) seen++;
    end
    tb_out_ready[0] = 1'b0;
    check("abort no output", 128'(seen), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
